// File: rtl/booth_mul_scheduler.sv
// Round-robin front end that shares one sequential signed multiplier among NREQ requesters.
// Optional feature: define ZERO_BYPASS_EN to answer zero-operand requests without using the multiplier.
module booth_mul_scheduler #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_x,
    input  logic [NREQ*W-1:0] req_y,
    output logic [NREQ-1:0]   req_ready,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [IDW-1:0]    resp_id,
    output logic [2*W-1:0]    resp_p,
    output logic              mul_start,
    output logic [W-1:0]      mul_x,
    output logic [W-1:0]      mul_y,
    input  logic              mul_done,
    input  logic [2*W-1:0]    mul_p,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] win_id;
    logic [IDW-1:0] cand;
    logic           win_found;
    logic [W-1:0]   win_x, win_y;
    logic           accept;
    logic           zero_op;

    // First valid requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = IDW'((32'(rr_ptr) + i) % 32'(NREQ));
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    assign win_x = req_x[win_id*W +: W];
    assign win_y = req_y[win_id*W +: W];

`ifdef ZERO_BYPASS_EN
    assign zero_op = (win_x == '0) || (win_y == '0);
`else
    assign zero_op = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        mul_start  = 1'b0;
        resp_valid = 1'b0;
        accept     = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (win_found) begin
                    req_ready[win_id] = 1'b1;
                    accept            = 1'b1;
                    state_nxt         = zero_op ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                mul_start = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (mul_done) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operands and id are captured at accept so requesters may change them afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr  <= '0;
            mul_x   <= '0;
            mul_y   <= '0;
            resp_id <= '0;
            resp_p  <= '0;
        end else begin
            if (accept) begin
                rr_ptr  <= IDW'((32'(win_id) + 32'd1) % 32'(NREQ));
                mul_x   <= win_x;
                mul_y   <= win_y;
                resp_id <= win_id;
                if (zero_op) begin
                    resp_p <= '0;
                end
            end
            if (state == WAIT && mul_done) begin
                resp_p <= mul_p;
            end
        end
    end

endmodule

// File: tb/tb_booth_mul_scheduler.sv
// Self-checking bench for booth_mul_scheduler: transaction-level reference model plus directed corner cases.
`timescale 1ns/1ps
module tb_booth_mul_scheduler;
    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*W-1:0] req_x = '0;
    logic [NREQ*W-1:0] req_y = '0;
    logic [NREQ-1:0]   req_ready;
    logic              resp_valid;
    logic              resp_ready = 1'b1;
    logic [IDW-1:0]    resp_id;
    logic [2*W-1:0]    resp_p;
    logic              mul_start;
    logic [W-1:0]      mul_x, mul_y;
    logic              mul_done = 1'b0;
    logic [2*W-1:0]    mul_p = '0;
    logic              busy;

    booth_mul_scheduler #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_p(resp_p),
        .mul_start(mul_start), .mul_x(mul_x), .mul_y(mul_y),
        .mul_done(mul_done), .mul_p(mul_p), .busy(busy)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++)
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++)
            if (v[k]) return k;
        return -1;
    endfunction

    // Multiplier model: done 9 cycles after start, product of the held operands.
    int unsigned    done_at = 32'hFFFF_FFFF;
    logic [2*W-1:0] pend_p = '0;
    bit             stray_arm = 0, stray_now = 0, stray_next = 0;
    int             start_cnt = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (mul_start) begin
                done_at   = cyc + 9;
                pend_p    = $signed(mul_x) * $signed(mul_y);
                start_cnt = start_cnt + 1;
            end
            stray_next = stray_arm && ((req_valid & req_ready) != '0);
            @(posedge clk);
            #1;
            mul_done = (cyc == done_at) || stray_next || stray_now;
            mul_p    = (cyc == done_at) ? pend_p : 16'h5A5A;
            if (stray_next) stray_arm = 0;
            stray_now = 0;
        end
    end

    // Reference model: one operation in flight, tracked by its accept and done cycles.
    bit             m_valid = 0, m_busy = 0, m_done_seen = 0, m_bypass = 0;
    int             m_rr = 0, m_acc = 0, m_done = 0;
    logic [W-1:0]   e_x = '0, e_y = '0;
    logic [IDW-1:0] e_id = '0;
    logic [2*W-1:0] e_p = '0;

    always @(negedge clk) begin : ref_model
        int             w, c;
        logic [NREQ-1:0] er;
        bit             erv;
        c   = int'(cyc);
        w   = rr_pick(req_valid, m_rr);
        erv = 0;
        if (m_valid) begin
            er = '0;
            if (!m_busy && w >= 0) er[w] = 1'b1;
            erv = m_busy && m_done_seen && (c > m_done);
            check("req_ready", req_ready, er);
            check("busy", busy, m_busy);
            check("mul_start", mul_start, m_busy && !m_bypass && (c == m_acc + 1));
            check("mul_x", mul_x, e_x);
            check("mul_y", mul_y, e_y);
            check("resp_valid", resp_valid, erv);
            check("resp_id", resp_id, e_id);
            check("resp_p", resp_p, e_p);
        end
        if (rst) begin
            m_valid = 1; m_busy = 0; m_done_seen = 0; m_bypass = 0; m_rr = 0;
            e_x = '0; e_y = '0; e_id = '0; e_p = '0;
        end else if (m_valid) begin
            if (erv && resp_ready) begin
                m_busy = 0;
            end else if (m_busy && !m_bypass && !m_done_seen && mul_done && c >= m_acc + 2) begin
                m_done_seen = 1;
                m_done      = c;
                e_p         = $signed(e_x) * $signed(e_y);
            end else if (!m_busy && w >= 0) begin
                m_busy = 1; m_done_seen = 0; m_bypass = 0; m_acc = c;
                e_x  = req_x[w*W +: W];
                e_y  = req_y[w*W +: W];
                e_id = IDW'(w);
                m_rr = (w + 1) % NREQ;
`ifdef ZERO_BYPASS_EN
                if (e_x == '0 || e_y == '0) begin
                    m_bypass = 1; m_done_seen = 1; m_done = c; e_p = '0;
                end
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int i, input logic [W-1:0] x, input logic [W-1:0] y);
        bit got = 0;
        req_valid[i] = 1'b1;
        req_x[i*W +: W] = x;
        req_y[i*W +: W] = y;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (req_ready[i]) got = 1;
        end
        check("accept_timeout", got, 1);
        tick();
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_resp();
        bit got = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (resp_valid) got = 1;
        end
        check("resp_timeout", got, 1);
    endtask

    task automatic wait_idle();
        bit got = 0;
        for (int k = 0; k < 80 && !got; k++) begin
            @(negedge clk);
            if (!busy) got = 1;
        end
        check("idle_timeout", got, 1);
        tick();
    endtask

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return 8'h80;
            2:       return 8'h7F;
            default: return W'($urandom);
        endcase
    endfunction

    localparam int EXP_ORDER [5] = '{0, 1, 2, 3, 0};

    initial begin
        int             s0, n;
        int             g [5];
        logic [2*W-1:0] p0;
        logic [IDW-1:0] id0;
        logic [NREQ-1:0] acc;

        // Reset values, then a stray done while idle.
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_mul_start", mul_start, 0);
        check("rst_mul_x", mul_x, 0);
        check("rst_resp_p", resp_p, 0);
        check("rst_req_ready", req_ready, 0);
        stray_now = 1;
        tick(); tick();
        @(negedge clk);
        check("stray_busy", busy, 0);
        check("stray_resp_valid", resp_valid, 0);
        tick();

        // Single request, with a done pulse landing in the start cycle.
        s0 = start_cnt;
        stray_arm = 1;
        issue(0, 8'd5, 8'hFD);
        @(negedge clk);
        check("t1_mul_start", mul_start, 1);
        check("t1_mul_x", mul_x, 8'h05);
        check("t1_mul_y", mul_y, 8'hFD);
        wait_resp();
        check("t1_resp_id", resp_id, 0);
        check("t1_resp_p", resp_p, 16'hFFF1);
        check("t1_starts", start_cnt - s0, 1);
        tick();

        // Round-robin with all requesters valid.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            req_x[i*W +: W] = W'($urandom);
            req_y[i*W +: W] = W'($urandom);
        end
        req_valid = '1;
        resp_ready = 1'b1;
        n = 0;
        for (int k = 0; k < 300 && n < 5; k++) begin
            @(negedge clk);
            if ((req_valid & req_ready) != '0) begin
                g[n] = onehot_idx(req_ready);
                n++;
            end
        end
        tick();
        req_valid = '0;
        check("rr_grants", n, 5);
        for (int k = 0; k < 5; k++) check("rr_order", g[k], EXP_ORDER[k]);
        wait_idle();

        // Backpressure in RESP.
        resp_ready = 1'b0;
        issue(2, 8'd9, 8'd11);
        wait_resp();
        p0 = resp_p;
        id0 = resp_id;
        check("bp_resp_p", p0, 16'd99);
        check("bp_resp_id", id0, 2);
        tick();
        req_valid[1] = 1'b1;
        req_x[1*W +: W] = 8'd3;
        req_y[1*W +: W] = 8'd4;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_hold_valid", resp_valid, 1);
            check("bp_hold_p", resp_p, p0);
            check("bp_hold_id", resp_id, id0);
            check("bp_req_ready", req_ready, 0);
            tick();
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check("bp_hs_valid", resp_valid, 1);
        check("bp_hs_req_ready", req_ready, 0);
        tick();
        @(negedge clk);
        check("bp_next_accept", req_ready, 4'b0010);
        tick();
        req_valid[1] = 1'b0;
        wait_resp();
        check("bp2_resp_p", resp_p, 16'd12);
        check("bp2_resp_id", resp_id, 1);
        tick();

        // Corner products.
        issue(3, 8'h80, 8'h80);
        wait_resp();
        check("corner_neg_neg", resp_p, 16'h4000);
        tick();
        issue(0, 8'h7F, 8'h80);
        wait_resp();
        check("corner_pos_neg", resp_p, 16'hC080);
        tick();

        // Reset while waiting for the multiplier.
        issue(1, 8'd7, 8'd7);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_mul_x", mul_x, 0);
        check("mid_rst_mul_y", mul_y, 0);
        check("mid_rst_resp_id", resp_id, 0);
        check("mid_rst_resp_p", resp_p, 0);
        check("mid_rst_mul_start", mul_start, 0);
        for (int k = 0; k < 15; k++) begin
            tick();
            @(negedge clk);
            check("mid_rst_no_resp", resp_valid, 0);
            check("mid_rst_busy", busy, 0);
        end
        tick();
        req_valid = '1;
        @(negedge clk);
        check("mid_rst_rr_ptr", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        wait_resp();
        tick();

        // Zero operand.
        s0 = start_cnt;
        issue(2, 8'd0, 8'd7);
        wait_resp();
        check("zero_resp_p", resp_p, 0);
        check("zero_resp_id", resp_id, 2);
`ifdef ZERO_BYPASS_EN
        check("zero_starts", start_cnt - s0, 0);
`else
        check("zero_starts", start_cnt - s0, 1);
`endif
        tick();

        // Random traffic with random consumer backpressure.
        for (int t = 0; t < 600; t++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            tick();
            resp_ready = ($urandom_range(0, 2) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    req_valid[i] = 1'b1;
                    req_x[i*W +: W] = rnd_op();
                    req_y[i*W +: W] = rnd_op();
                end
            end
        end
        req_valid = '0;
        resp_ready = 1'b1;
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
